// File: rtl/uart_cmd_host.sv
// rtl/uart_cmd_host.sv - host-side UART command initiator: send one byte, collect a timed multi-byte response
// Optional UART_CMD_HOST_RETRY_EN: re-send the command after a response timeout, up to MaxRetries times.
module uart_cmd_host #(
  parameter int RespBytes     = 2,
  parameter int TimeoutCycles = 1000000,
  parameter int CntWidth      = 20,
  parameter int MaxRetries    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic [7:0]             cmd_i,
  output logic [7:0]             tx_data_o,
  output logic                   stt_o,
  input  logic                   eot_i,
  input  logic                   eor_i,
  input  logic [7:0]             rx_data_i,
  output logic [8*RespBytes-1:0] resp_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   timeout_o
);
  localparam int RW = 8 * RespBytes;
  localparam logic [CntWidth-1:0] TmoLast  = CntWidth'(TimeoutCycles - 1);
  localparam logic [2:0]          LastByte = 3'(RespBytes - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_EOT, WAIT_RX, DONE, TIMEOUT} state_e;

  state_e              state_q, state_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [RW-1:0]       shift_q, shift_d, resp_q, resp_d, shift_in;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [CntWidth-1:0] tmo_cnt_q, tmo_cnt_d;

  // First received byte ends up in the MSBs once all RespBytes have shifted in.
  generate
    if (RespBytes == 1) begin : g_one
      assign shift_in = rx_data_i;
    end else begin : g_multi
      assign shift_in = {shift_q[RW-9:0], rx_data_i};
    end
  endgenerate

`ifdef UART_CMD_HOST_RETRY_EN
  localparam int RtW = $clog2(MaxRetries + 1) + 1;
  localparam logic [RtW-1:0] RetryMax = RtW'(MaxRetries);
  logic [RtW-1:0] retry_q, retry_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) retry_q <= '0;
    else        retry_q <= retry_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    shift_d    = shift_q;
    resp_d     = resp_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
`ifdef UART_CMD_HOST_RETRY_EN
    retry_d    = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i) begin
          tx_data_d = cmd_i;
          state_d   = SEND;
`ifdef UART_CMD_HOST_RETRY_EN
          retry_d   = '0;
`endif
        end
      end
      SEND: state_d = WAIT_EOT;
      WAIT_EOT: begin
        if (eot_i) begin
          tmo_cnt_d  = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
          state_d    = WAIT_RX;
        end
      end
      WAIT_RX: begin
        // A byte on the expiry cycle still counts: eor_i is tested before the limit.
        if (eor_i) begin
          shift_d    = shift_in;
          byte_cnt_d = byte_cnt_q + 3'd1;
          tmo_cnt_d  = '0;
          if (byte_cnt_q == LastByte) begin
            resp_d  = shift_in;
            state_d = DONE;
          end
        end else if (tmo_cnt_q == TmoLast) begin
`ifdef UART_CMD_HOST_RETRY_EN
          if (retry_q != RetryMax) begin
            retry_d    = retry_q + RtW'(1);
            shift_d    = '0;
            byte_cnt_d = '0;
            state_d    = SEND;
          end else begin
            state_d = TIMEOUT;
          end
`else
          state_d = TIMEOUT;
`endif
        end else begin
          tmo_cnt_d = tmo_cnt_q + CntWidth'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef UART_CMD_HOST_RETRY_EN
        retry_d = '0;
`endif
      end
      TIMEOUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      shift_q    <= '0;
      resp_q     <= '0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      shift_q    <= shift_d;
      resp_q     <= resp_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign tx_data_o = tx_data_q;
  assign resp_o    = resp_q;
  assign stt_o     = (state_q == SEND);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign timeout_o = (state_q == TIMEOUT);
endmodule

// File: tb/tb_uart_cmd_host.sv
// tb/tb_uart_cmd_host.sv - self-checking bench for uart_cmd_host with a transaction-level reference model
module tb_uart_cmd_host;
  localparam int RESP = 2;
  localparam int TO   = 50;

  logic        clk_i = 1'b0, rst_i = 1'b0, req_i = 1'b0, eot_i = 1'b0, eor_i = 1'b0;
  logic [7:0]  cmd_i = 8'h00, rx_data_i = 8'h00;
  logic [7:0]  tx_data_o;
  logic        stt_o, busy_o, done_o, timeout_o;
  logic [15:0] resp_o;

  int total = 0, bad = 0;
  int cyc = 0, n_stt = 0, n_done = 0, n_tmo = 0, stt_cyc = 0, tmo_cyc = 0;
  logic [7:0]  last_tx = 8'h00;
  logic [15:0] last_resp = 16'h0;
  logic [15:0] model_resp = 16'h0;

  uart_cmd_host #(.RespBytes(RESP), .TimeoutCycles(TO), .CntWidth(6), .MaxRetries(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .cmd_i(cmd_i), .tx_data_o(tx_data_o),
    .stt_o(stt_o), .eot_i(eot_i), .eor_i(eor_i), .rx_data_i(rx_data_i), .resp_o(resp_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // Advance one cycle and log the pulses seen just after the edge.
  task automatic tick();
    @(posedge clk_i); #1;
    cyc++;
    if (stt_o)     begin n_stt++;  stt_cyc = cyc; last_tx = tx_data_o; end
    if (done_o)    begin n_done++; last_resp = resp_o; end
    if (timeout_o) begin n_tmo++;  tmo_cyc = cyc; end
  endtask

  // Reference: response completes iff every byte arrives within TO cycles of the previous event.
  function automatic bit model_ok(input int nb, input int gaps[4], input logic [7:0] bytes[4],
                                  output logic [15:0] resp);
    int r;
    r = 0;
    resp = 16'h0;
    if (nb < RESP) return 1'b0;
    for (int i = 0; i < RESP; i++) begin
      if (gaps[i] > TO - 1) return 1'b0;
      r = r * 256 + int'(bytes[i]);
    end
    resp = 16'(r);
    return 1'b1;
  endfunction

  task automatic do_txn(input logic [7:0] cmd, input int eot_dly, input int nb, input int gaps[4],
                        input logic [7:0] bytes[4], output int req_cyc, output int ev_cyc, output bit hung);
    bit aborted;
    aborted = 1'b0;
    req_i = 1'b1; cmd_i = cmd;
    tick();
    req_i = 1'b0; cmd_i = 8'($urandom);
    req_cyc = cyc;
    tick();
    repeat (eot_dly) tick();
    eot_i = 1'b1; tick(); eot_i = 1'b0;
    ev_cyc = cyc;
    for (int i = 0; i < nb && !aborted; i++) begin
      for (int g = 0; g < gaps[i] && !timeout_o; g++) tick();
      if (timeout_o) aborted = 1'b1;
      else begin
        eor_i = 1'b1; rx_data_i = bytes[i]; tick(); eor_i = 1'b0; rx_data_i = 8'($urandom);
        ev_cyc = cyc;
      end
    end
    hung = 1'b1;
    for (int k = 0; k < TO + 10; k++) begin
      if (!busy_o) begin hung = 1'b0; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req_i = 1'($urandom); cmd_i = 8'($urandom);
      tick();
      total++;
      if ({stt_o, busy_o, done_o, timeout_o} !== 4'b0 || tx_data_o !== 8'h00 || resp_o !== 16'h0) begin
        bad++;
        $display("FAIL reset_hold: stt=%b busy=%b done=%b tmo=%b tx=%h resp=%h, required all zero",
                 stt_o, busy_o, done_o, timeout_o, tx_data_o, resp_o);
      end
    end
    req_i = 1'b0; rst_i = 1'b1;
    repeat (3) tick();
    total++;
    if (busy_o !== 1'b0 || n_stt !== 0) begin
      bad++; $display("FAIL reset_release: busy=%b stt_pulses=%0d, required 0 and 0", busy_o, n_stt);
    end
  endtask

  task automatic test_nominal();
    int gaps[4] = '{3, 5, 0, 0};
    logic [7:0] bytes[4] = '{8'hA5, 8'h3C, 8'h00, 8'h00};
    int s0, d0, t0, rc, ec; bit hung;
    s0 = n_stt; d0 = n_done; t0 = n_tmo;
    do_txn(8'h41, 2, 2, gaps, bytes, rc, ec, hung);
    total++; if (hung) begin bad++; $display("FAIL nom_hang: busy still %b, required 0", busy_o); end
    total++;
    if (n_stt - s0 !== 1 || stt_cyc !== rc) begin
      bad++; $display("FAIL nom_stt: pulses=%0d at cyc %0d, required 1 at cyc %0d", n_stt - s0, stt_cyc, rc);
    end
    total++;
    if (last_tx !== 8'h41 || tx_data_o !== 8'h41) begin
      bad++; $display("FAIL nom_tx: at stt=%h now=%h, required 41", last_tx, tx_data_o);
    end
    total++;
    if (n_done - d0 !== 1 || last_resp !== 16'hA53C) begin
      bad++; $display("FAIL nom_done: pulses=%0d resp=%h, required 1 and a53c", n_done - d0, last_resp);
    end
    total++;
    if (resp_o !== 16'hA53C || n_tmo !== t0) begin
      bad++; $display("FAIL nom_hold: resp=%h tmo_pulses=%0d, required a53c and 0", resp_o, n_tmo - t0);
    end
    model_resp = 16'hA53C;
  endtask

  task automatic test_timeout();
    int gaps[4] = '{2, 0, 0, 0};
    logic [7:0] bytes[4] = '{8'h12, 8'h00, 8'h00, 8'h00};
    int d0, t0, rc, ec; bit hung;
    d0 = n_done; t0 = n_tmo;
    do_txn(8'h21, 0, 1, gaps, bytes, rc, ec, hung);
    total++;
    if (hung || n_tmo - t0 !== 1 || tmo_cyc - ec !== TO) begin
      bad++;
      $display("FAIL tmo_pulse: hung=%b pulses=%0d latency=%0d, required 0, 1, %0d", hung, n_tmo - t0, tmo_cyc - ec, TO);
    end
    total++;
    if (n_done !== d0 || resp_o !== model_resp) begin
      bad++; $display("FAIL tmo_resp: done_pulses=%0d resp=%h, required 0 and %h", n_done - d0, resp_o, model_resp);
    end
  endtask

  task automatic test_boundary();
    int gaps[4] = '{TO - 1, TO - 1, 0, 0};
    logic [7:0] bytes[4];
    logic [15:0] exp;
    int d0, t0, rc, ec; bit hung, ok;
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
    d0 = n_done; t0 = n_tmo;
    ok = model_ok(2, gaps, bytes, exp);
    do_txn(8'h6B, 1, 2, gaps, bytes, rc, ec, hung);
    total++;
    if (!ok || hung || n_done - d0 !== 1 || n_tmo !== t0 || resp_o !== exp) begin
      bad++;
      $display("FAIL edge_accept: done=%0d tmo=%0d resp=%h, required 1, 0, %h", n_done - d0, n_tmo - t0, resp_o, exp);
    end
    model_resp = exp;
`ifndef UART_CMD_HOST_RETRY_EN
    gaps[0] = 1; gaps[1] = TO;
    d0 = n_done; t0 = n_tmo;
    do_txn(8'h6C, 0, 2, gaps, bytes, rc, ec, hung);
    total++;
    if (hung || n_tmo - t0 !== 1 || n_done !== d0 || tmo_cyc - ec !== TO || resp_o !== model_resp) begin
      bad++;
      $display("FAIL edge_expire: tmo=%0d done=%0d latency=%0d resp=%h, required 1, 0, %0d, %h",
               n_tmo - t0, n_done - d0, tmo_cyc - ec, resp_o, TO, model_resp);
    end
`endif
  endtask

  task automatic test_ignored();
    int s0, d0;
    s0 = n_stt; d0 = n_done;
    req_i = 1'b1; cmd_i = 8'h5A; tick(); req_i = 1'b0;
    tick();
    eor_i = 1'b1; rx_data_i = 8'hEE; req_i = 1'b1; cmd_i = 8'h99; tick(); eor_i = 1'b0;
    repeat (3) tick();
    eot_i = 1'b1; tick(); eot_i = 1'b0;
    eor_i = 1'b1; rx_data_i = 8'h11; tick();
    rx_data_i = 8'h22; tick();
    eor_i = 1'b0; req_i = 1'b0;
    repeat (4) tick();
    total++;
    if (n_done - d0 !== 1 || resp_o !== 16'h1122) begin
      bad++; $display("FAIL ign_resp: done=%0d resp=%h, required 1 and 1122", n_done - d0, resp_o);
    end
    total++;
    if (n_stt - s0 !== 1 || tx_data_o !== 8'h5A || busy_o !== 1'b0) begin
      bad++; $display("FAIL ign_req: stt=%0d tx=%h busy=%b, required 1, 5a, 0", n_stt - s0, tx_data_o, busy_o);
    end
    model_resp = 16'h1122;
  endtask

  task automatic test_random();
    int gaps[4];
    logic [7:0] bytes[4];
    logic [7:0] cmd;
    logic [15:0] exp;
    int nb, s0, d0, t0, rc, ec; bit hung, ok;
    for (int n = 0; n < 12; n++) begin
      cmd = 8'($urandom);
      nb = int'($urandom_range(1, 2));
      for (int i = 0; i < 4; i++) begin
        bytes[i] = 8'($urandom);
        gaps[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO + 2)) : int'($urandom_range(0, 10));
`ifdef UART_CMD_HOST_RETRY_EN
        if (gaps[i] > TO - 1) gaps[i] = TO - 1;
`endif
      end
`ifdef UART_CMD_HOST_RETRY_EN
      nb = RESP;
`endif
      ok = model_ok(nb, gaps, bytes, exp);
      s0 = n_stt; d0 = n_done; t0 = n_tmo;
      do_txn(cmd, int'($urandom_range(0, 4)), nb, gaps, bytes, rc, ec, hung);
      total++;
      if (hung || n_stt - s0 !== 1 || last_tx !== cmd) begin
        bad++; $display("FAIL rnd%0d_send: hung=%b stt=%0d tx=%h, required 0, 1, %h", n, hung, n_stt - s0, last_tx, cmd);
      end
      if (ok) begin
        total++;
        if (n_done - d0 !== 1 || n_tmo !== t0 || resp_o !== exp) begin
          bad++; $display("FAIL rnd%0d_done: done=%0d tmo=%0d resp=%h, required 1, 0, %h", n, n_done - d0, n_tmo - t0, resp_o, exp);
        end
        model_resp = exp;
      end else begin
        total++;
        if (n_tmo - t0 !== 1 || n_done !== d0 || tmo_cyc - ec !== TO || resp_o !== model_resp) begin
          bad++;
          $display("FAIL rnd%0d_tmo: tmo=%0d done=%0d latency=%0d resp=%h, required 1, 0, %0d, %h",
                   n, n_tmo - t0, n_done - d0, tmo_cyc - ec, resp_o, TO, model_resp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0, t0;
    req_i = 1'b1; cmd_i = 8'h77; tick(); req_i = 1'b0;
    tick();
    eot_i = 1'b1; tick(); eot_i = 1'b0;
    eor_i = 1'b1; rx_data_i = 8'h33; tick(); eor_i = 1'b0;
    repeat (5) tick();
    d0 = n_done; t0 = n_tmo;
    #2; rst_i = 1'b0; #1;
    total++;
    if (busy_o !== 1'b0 || stt_o !== 1'b0 || resp_o !== 16'h0 || tx_data_o !== 8'h00) begin
      bad++; $display("FAIL mid_reset: busy=%b stt=%b resp=%h tx=%h, required all zero", busy_o, stt_o, resp_o, tx_data_o);
    end
    repeat (3) tick();
    rst_i = 1'b1;
    repeat (TO + 5) tick();
    total++;
    if (n_done !== d0 || n_tmo !== t0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL mid_quiet: done=%0d tmo=%0d busy=%b, required 0, 0, 0", n_done - d0, n_tmo - t0, busy_o);
    end
    model_resp = 16'h0;
  endtask

`ifdef UART_CMD_HOST_RETRY_EN
  task automatic retry_run(input logic [7:0] cmd, input int serve_on, input logic [7:0] b0, input logic [7:0] b1,
                           output int tx_bad, output bit hung);
    int att, phase;
    att = 0; phase = 0; tx_bad = 0; hung = 1'b1;
    req_i = 1'b1; cmd_i = cmd; tick(); req_i = 1'b0;
    for (int k = 0; k < 8 * TO; k++) begin
      eot_i = 1'b0; eor_i = 1'b0;
      if (stt_o) begin
        att++; phase = 1;
        if (tx_data_o !== cmd) tx_bad++;
      end else if (phase == 1) begin
        eot_i = 1'b1; phase = (att == serve_on) ? 2 : 0;
      end else if (phase == 2) begin
        eor_i = 1'b1; rx_data_i = b0; phase = 3;
      end else if (phase == 3) begin
        eor_i = 1'b1; rx_data_i = b1; phase = 0;
      end else if (!busy_o) begin
        hung = 1'b0; break;
      end
      tick();
    end
    eot_i = 1'b0; eor_i = 1'b0;
  endtask

  task automatic test_retry();
    int s0, d0, t0, txb; bit hung;
    logic [7:0] b0, b1;
    s0 = n_stt; d0 = n_done; t0 = n_tmo;
    retry_run(8'hC3, 0, 8'h00, 8'h00, txb, hung);
    total++;
    if (hung || n_stt - s0 !== 3 || txb !== 0) begin
      bad++; $display("FAIL retry_resend: hung=%b stt=%0d bad_tx=%0d, required 0, 3, 0", hung, n_stt - s0, txb);
    end
    total++;
    if (n_tmo - t0 !== 1 || n_done !== d0 || resp_o !== model_resp) begin
      bad++; $display("FAIL retry_final: tmo=%0d done=%0d resp=%h, required 1, 0, %h", n_tmo - t0, n_done - d0, resp_o, model_resp);
    end
    b0 = 8'($urandom); b1 = 8'($urandom);
    s0 = n_stt; d0 = n_done; t0 = n_tmo;
    retry_run(8'h4E, 2, b0, b1, txb, hung);
    total++;
    if (hung || n_stt - s0 !== 2 || n_done - d0 !== 1 || n_tmo !== t0 || resp_o !== {b0, b1}) begin
      bad++;
      $display("FAIL retry_second: hung=%b stt=%0d done=%0d tmo=%0d resp=%h, required 0, 2, 1, 0, %h",
               hung, n_stt - s0, n_done - d0, n_tmo - t0, resp_o, {b0, b1});
    end
    model_resp = {b0, b1};
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
`ifndef UART_CMD_HOST_RETRY_EN
    test_timeout();
`endif
    test_boundary();
    test_ignored();
    test_random();
    test_reset_mid();
`ifdef UART_CMD_HOST_RETRY_EN
    test_retry();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
